// File: rtl/fp_mul_pl_if.sv
// Operand/result handshake bundle for the pipelined single-precision multiplier.
//   A, B   : operand pair (IEEE-754 single)
//   D      : issue strobe, operands taken on an edge when D=1 and RDY=1
//   RDY    : multiplier can take an operand pair this cycle
//   C      : product, meaningful only while V=1 (zero otherwise)
//   V      : C holds a valid result
//   C_RDY  : consumer takes C on an edge when V=1 and C_RDY=1
// The master is the upstream/downstream environment; the slave is the multiplier.
interface fp_mul_pl_if;
   logic [31:0] A;
   logic [31:0] B;
   logic        D;
   logic        RDY;
   logic [31:0] C;
   logic        V;
   logic        C_RDY;

   modport master (output A, B, D, C_RDY, input RDY, C, V);
   modport slave  (input A, B, D, C_RDY, output RDY, C, V);
endinterface

// File: rtl/fp_mul_pl.sv
// Three-stage pipelined IEEE-754 single-precision multiplier.
//   S1 unpacks (sign, biased exponent sum, hidden-1 mantissas), S2 holds the
//   registered 24x24 product, S3 normalizes, truncates and packs the result.
//   Each stage carries a valid bit; the whole pipe freezes while a valid
//   result waits for a consumer that is not ready.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset, flushes every stage
//   bus  : fp_mul_pl_if slave (A, B, D, RDY, C, V, C_RDY)
// Configuration:
//   FP_MUL_SPECIAL_EN : when defined, exponent field 8'hFF decodes as Inf/NaN
//                       (NaN in or Inf*0 -> 7FC00000, Inf*finite -> signed Inf).
//                       When undefined, 8'hFF is an ordinary exponent.
module fp_mul_pl (
   input logic        clk,
   input logic        rst,
   fp_mul_pl_if.slave bus
);
   logic stall;
   logic accept;

   // Unpack results (combinational, captured into S1)
   logic [9:0]  u_exp;
   logic        u_zero;
`ifdef FP_MUL_SPECIAL_EN
   logic        u_nan;
   logic        u_inf;
   logic        a_ff, b_ff, a_z, b_z;
`endif

   // Stage registers
   logic              s1_v, s1_sign, s1_zero;
   logic signed [9:0] s1_exp;
   logic [23:0]       s1_ma, s1_mb;
   logic              s2_v, s2_sign, s2_zero;
   logic signed [9:0] s2_exp;
   logic [47:0]       s2_p;
`ifdef FP_MUL_SPECIAL_EN
   logic              s1_nan, s1_inf, s2_nan, s2_inf;
`endif
   logic              s3_v;
   logic [31:0]       s3_c;

   // Normalize/pack results (combinational, captured into S3)
   logic signed [9:0] n_exp;
   logic [31:0]       n_c;
   logic              unused_p;

   assign stall   = s3_v & ~bus.C_RDY;
   assign accept  = bus.D & ~stall;
   assign bus.RDY = ~stall;
   assign bus.V   = s3_v;
   assign bus.C   = s3_v ? s3_c : 32'h0;

   // Truncation discards the low product bits entirely.
   assign unused_p = ^s2_p[22:0];

   always_comb begin
      // Biased sum eA+eB-127; 10 bits signed covers -125..383.
      u_exp  = {2'b00, bus.A[30:23]} + {2'b00, bus.B[30:23]} - 10'd127;
      u_zero = (bus.A[30:23] == 8'h00) | (bus.B[30:23] == 8'h00);
`ifdef FP_MUL_SPECIAL_EN
      a_ff  = (bus.A[30:23] == 8'hFF);
      b_ff  = (bus.B[30:23] == 8'hFF);
      a_z   = (bus.A[30:23] == 8'h00);
      b_z   = (bus.B[30:23] == 8'h00);
      u_nan = (a_ff & ((|bus.A[22:0]) | b_z)) | (b_ff & ((|bus.B[22:0]) | a_z));
      u_inf = a_ff | b_ff;
`endif
   end

   // S1: unpack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: data registers are cleared with the valid bits so a reset leaves no stale operand anywhere in the pipe.
         s1_v    <= 1'b0;
         s1_sign <= 1'b0;
         s1_zero <= 1'b0;
         s1_exp  <= '0;
         s1_ma   <= '0;
         s1_mb   <= '0;
`ifdef FP_MUL_SPECIAL_EN
         s1_nan  <= 1'b0;
         s1_inf  <= 1'b0;
`endif
      end else if (!stall) begin
         // NOTE: non-blocking assignments make every stage sample pre-edge values, so data moves exactly one stage per edge.
         s1_v <= accept;
         if (accept) begin
            s1_sign <= bus.A[31] ^ bus.B[31];
            s1_zero <= u_zero;
            s1_exp  <= u_exp;
            s1_ma   <= {1'b1, bus.A[22:0]};
            s1_mb   <= {1'b1, bus.B[22:0]};
`ifdef FP_MUL_SPECIAL_EN
            s1_nan  <= u_nan;
            s1_inf  <= u_inf;
`endif
         end
      end
   end

   // S2: registered multiply
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_v    <= 1'b0;
         s2_sign <= 1'b0;
         s2_zero <= 1'b0;
         s2_exp  <= '0;
         s2_p    <= '0;
`ifdef FP_MUL_SPECIAL_EN
         s2_nan  <= 1'b0;
         s2_inf  <= 1'b0;
`endif
      end else if (!stall) begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_exp  <= s1_exp;
            s2_p    <= {24'h0, s1_ma} * {24'h0, s1_mb};
`ifdef FP_MUL_SPECIAL_EN
            s2_nan  <= s1_nan;
            s2_inf  <= s1_inf;
`endif
         end
      end
   end

   // Normalize, truncate, apply range and special rules
   always_comb begin
      // NOTE: n_c gets a full default before any conditional override, so no path can infer a latch.
      n_exp = s2_exp + $signed({9'b0, s2_p[47]});
      n_c   = {s2_sign, n_exp[7:0], (s2_p[47] ? s2_p[46:24] : s2_p[45:23])};
      if (s2_zero || (n_exp <= 10'sd0))
         n_c = {s2_sign, 31'h0};
      else if (n_exp >= 10'sd255)
         n_c = {s2_sign, 8'hFF, 23'h0};
`ifdef FP_MUL_SPECIAL_EN
      // Special operands outrank the zero/range rules.
      if (s2_nan)
         n_c = 32'h7FC00000;
      else if (s2_inf)
         n_c = {s2_sign, 8'hFF, 23'h0};
`endif
   end

   // S3: result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_v <= 1'b0;
         s3_c <= '0;
      end else if (!stall) begin
         s3_v <= s2_v;
         if (s2_v)
            s3_c <= n_c;
      end
   end
endmodule

// File: tb/tb_fp_mul_pl.sv
// Self-checking bench for fp_mul_pl: directed scenarios plus randomized
// traffic against a value-level reference model of the multiply rules.
module tb_fp_mul_pl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_mul_pl_if bus ();
   fp_mul_pl dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;
   int tick_n = 0;
   logic        s_v, s_rdy;
   logic [31:0] s_c;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   int          got_t[$];

   // Reference: exact mantissa product, leading-one search, truncation.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic sign;
      int ea, eb, t, e;
      longint unsigned ma, mb, prod;
`ifdef FP_MUL_SPECIAL_EN
      bit a_inf, b_inf, a_nan, b_nan;
`endif
      sign = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
`ifdef FP_MUL_SPECIAL_EN
      a_inf = (ea == 255) && (a[22:0] == 0);
      b_inf = (eb == 255) && (b[22:0] == 0);
      a_nan = (ea == 255) && (a[22:0] != 0);
      b_nan = (eb == 255) && (b[22:0] != 0);
      if (a_nan || b_nan || (a_inf && eb == 0) || (b_inf && ea == 0)) return 32'h7FC00000;
      if (a_inf || b_inf) return {sign, 8'hFF, 23'h0};
`endif
      if (ea == 0 || eb == 0) return {sign, 31'h0};
      ma = 64'h800000 | 64'(a[22:0]);
      mb = 64'h800000 | 64'(b[22:0]);
      prod = ma * mb;                 // value = prod * 2^(ea+eb-254-46)
      t = 0;
      for (int i = 0; i < 64; i++) if (prod[i]) t = i;
      e = ea + eb - 127 + (t - 46);
      if (e <= 0)   return {sign, 31'h0};
      if (e >= 255) return {sign, 8'hFF, 23'h0};
      return {sign, 8'(e), 23'((prod >> (t - 23)) & 64'h7FFFFF)};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0] ex;
      case ($urandom_range(0, 9))
         0: ex = 8'h00;
         1: ex = 8'($urandom_range(1, 12));
         2: ex = 8'($urandom_range(240, 254));
         3: ex = 8'hFF;
         default: ex = 8'($urandom_range(100, 155));
      endcase
      return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
   endfunction

   // One clock: sample at the falling edge, record accepted issues and
   // consumed results, then return 1 ns after the rising edge.
   task automatic tick();
      @(negedge clk);
      s_v   = bus.V;
      s_c   = bus.C;
      s_rdy = bus.RDY;
      if (!rst && bus.D && bus.RDY) exp_q.push_back(ref_mul(bus.A, bus.B));
      if (bus.V && bus.C_RDY) begin
         got_q.push_back(bus.C);
         got_t.push_back(tick_n);
      end
      @(posedge clk);
      #1;
      tick_n++;
   endtask

   task automatic clear_q();
      exp_q.delete();
      got_q.delete();
      got_t.delete();
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      bus.A = a;
      bus.B = b;
      bus.D = 1'b1;
      tick();
      bus.D = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.A = 32'h3FC00000;
      bus.B = 32'h40000000;
      bus.D = 1'b1;
      bus.C_RDY = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.V !== 1'b0) begin n_bad++; $display("FAIL reset_v: got %b expected 0", bus.V); end
      n_cmp++; if (bus.C !== 32'h0) begin n_bad++; $display("FAIL reset_c: got %h expected 00000000", bus.C); end
      n_cmp++; if (bus.RDY !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b expected 1", bus.RDY); end
      #1 rst = 1'b0;
      clear_q();
      // D already high: the first rising edge after release must accept.
      for (int i = 0; i < 5; i++) begin
         tick();
         bus.D = 1'b0;
         n_cmp++;
         if (s_v !== (i == 3)) begin n_bad++; $display("FAIL first_edge_v[%0d]: got %b expected %b", i, s_v, (i == 3)); end
      end
      n_cmp++; if (got_q.size() != 1 || got_q[0] !== 32'h40400000) begin
         n_bad++; $display("FAIL first_edge_c: got %0d results first %h expected 1 result 40400000", got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx);
      end
   endtask

   task automatic test_latency();
      clear_q();
      bus.A = 32'h3FC00000;
      bus.B = 32'h40000000;
      for (int i = 0; i < 6; i++) begin
         bus.D = (i == 0);
         tick();
         n_cmp++;
         if (s_v !== (i == 3)) begin n_bad++; $display("FAIL latency_v[%0d]: got %b expected %b", i, s_v, (i == 3)); end
         if (i == 3) begin
            n_cmp++;
            if (s_c !== 32'h40400000) begin n_bad++; $display("FAIL latency_c: got %h expected 40400000", s_c); end
         end
      end
      bus.D = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a_t[4] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h00000000};
      logic [31:0] b_t[4] = '{32'h3F800000, 32'h3FC00000, 32'hC0400000, 32'h40A00000};
      logic [31:0] c_t[4] = '{32'h3F800000, 32'h40100000, 32'hC0C00000, 32'h00000000};
      clear_q();
      for (int i = 0; i < 4; i++) begin
         bus.A = a_t[i];
         bus.B = b_t[i];
         bus.D = 1'b1;
         tick();
      end
      bus.D = 1'b0;
      repeat (6) tick();
      n_cmp++;
      if (got_q.size() != 4) begin n_bad++; $display("FAIL b2b_count: got %0d expected 4", got_q.size()); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== c_t[i]) begin n_bad++; $display("FAIL b2b_c[%0d]: got %h expected %h", i, got_q[i], c_t[i]); end
         n_cmp++;
         if (got_t[i] != got_t[0] + i) begin n_bad++; $display("FAIL b2b_gap[%0d]: got tick %0d expected %0d", i, got_t[i], got_t[0] + i); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      clear_q();
      for (int i = 0; i < 3; i++) issue(rand_op(), rand_op());
      bus.C_RDY = 1'b0;
      held = exp_q[0];
      for (int i = 0; i < 5; i++) begin
         // An issue attempt while stalled must be ignored.
         bus.D = (i == 2);
         bus.A = 32'h40000000;
         bus.B = 32'h40000000;
         tick();
         n_cmp++;
         if (s_rdy !== 1'b0) begin n_bad++; $display("FAIL stall_rdy[%0d]: got %b expected 0", i, s_rdy); end
         n_cmp++;
         if (s_v !== 1'b1 || s_c !== held) begin n_bad++; $display("FAIL stall_hold[%0d]: got v=%b c=%h expected v=1 c=%h", i, s_v, s_c, held); end
      end
      bus.D = 1'b0;
      bus.C_RDY = 1'b1;
      repeat (6) tick();
      n_cmp++;
      if (got_q.size() != 3 || exp_q.size() != 3) begin n_bad++; $display("FAIL stall_count: got %0d results (%0d issued) expected 3", got_q.size(), exp_q.size()); end
      for (int i = 0; i < 3 && i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i] || got_t[i] != got_t[0] + i) begin
            n_bad++; $display("FAIL stall_drain[%0d]: got %h at tick %0d expected %h at tick %0d", i, got_q[i], got_t[i], exp_q[i], got_t[0] + i);
         end
      end
   endtask

   task automatic test_corners();
`ifdef FP_MUL_SPECIAL_EN
      localparam int N = 5;
      logic [31:0] a_t[N] = '{32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F800000, 32'hFF800000};
      logic [31:0] b_t[N] = '{32'h40000000, 32'h00800000, 32'h3F800000, 32'h00000000, 32'h40000000};
      logic [31:0] c_t[N] = '{32'h7F800000, 32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000};
`else
      localparam int N = 4;
      // Without special decoding 8'hFF is an ordinary exponent: 255+126-127 = 254.
      logic [31:0] a_t[N] = '{32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F800000};
      logic [31:0] b_t[N] = '{32'h40000000, 32'h00800000, 32'h3F800000, 32'h3F000000};
      logic [31:0] c_t[N] = '{32'h7F800000, 32'h00000000, 32'h80000000, 32'h7F000000};
`endif
      clear_q();
      for (int i = 0; i < N; i++) issue(a_t[i], b_t[i]);
      repeat (6) tick();
      n_cmp++;
      if (got_q.size() != N) begin n_bad++; $display("FAIL corner_count: got %0d expected %0d", got_q.size(), N); end
      for (int i = 0; i < N && i < got_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== c_t[i]) begin n_bad++; $display("FAIL corner_c[%0d]: got %h expected %h", i, got_q[i], c_t[i]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      issue(32'h40400000, 32'h40400000);
      issue(32'h3FC00000, 32'h3FC00000);
      tick();
      n_cmp++;
      if (bus.V !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_v: got %b expected 1", bus.V); end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.V !== 1'b0 || bus.C !== 32'h0 || bus.RDY !== 1'b1) begin
         n_bad++; $display("FAIL rmid_async: got v=%b c=%h rdy=%b expected v=0 c=0 rdy=1", bus.V, bus.C, bus.RDY);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      clear_q();
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (s_v !== 1'b0) begin n_bad++; $display("FAIL rmid_flushed[%0d]: got v=%b expected 0", i, s_v); end
      end
      bus.A = 32'h40A00000;
      bus.B = 32'hBF000000;
      for (int i = 0; i < 5; i++) begin
         bus.D = (i == 0);
         tick();
         n_cmp++;
         if (s_v !== (i == 3) || (i == 3 && s_c !== 32'hC0200000)) begin
            n_bad++; $display("FAIL rmid_next[%0d]: got v=%b c=%h expected v=%b c=C0200000", i, s_v, s_c, (i == 3));
         end
      end
      bus.D = 1'b0;
   endtask

   task automatic test_random();
      clear_q();
      for (int i = 0; i < 400; i++) begin
         bus.A = rand_op();
         bus.B = rand_op();
         bus.D = 1'($urandom_range(0, 1));
         bus.C_RDY = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.D = 1'b0;
      bus.C_RDY = 1'b1;
      repeat (8) tick();
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d results expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_c[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.A = '0;
      bus.B = '0;
      bus.D = 1'b0;
      bus.C_RDY = 1'b1;
      test_reset();
      test_latency();
      test_back_to_back();
      test_stall();
      test_corners();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
